// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed 4x4 hex keypad scanner with debounce and a
// valid/ack holding register for the accepted key code.
module keypad_scanner #(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] cols,
  input  logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic [3:0]            rows_meta_q, rows_s_q;
  logic [SCAN_DIV_W-1:0] div_q, div_d;
  state_t                state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [1:0]            row_q, row_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic       tick, hit, row_lo, accept, ack_ok;
  logic [1:0] row_sel;
  logic [3:0] cnt_inc;

  // Two-flop synchronizer; idle level is all-ones (no key down).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      rows_meta_q <= rows;
      rows_s_q    <= rows_meta_q;
    end
  end

  // Lowest-index active row wins when several rows are low.
  always_comb begin
    row_sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!rows_s_q[i]) row_sel = 2'(i);
  end

  assign div_d   = div_q + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
  assign tick    = &div_q;
  assign hit     = ~&rows_s_q;
  assign row_lo  = ~rows_s_q[row_q];
  assign cnt_inc = cnt_q + 4'd1;
  assign ack_ok  = key_ack & valid_q;

  // Scan/debounce FSM: evaluated only on tick cycles; column frozen outside SCAN.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            row_d = row_sel;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              cnt_d   = 4'd0;
              state_d = HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_lo) begin
            if (cnt_inc >= DB_N) begin
              accept  = 1'b1;
              cnt_d   = 4'd0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 4'd0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Count consecutive release ticks of the latched row only.
          if (!row_lo) begin
            if (cnt_inc >= DB_N) begin
              cnt_d   = 4'd0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Holding register: ack frees the slot; an accept into an occupied,
  // un-acked slot is dropped and flagged as overrun.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (ack_ok) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (accept) begin
      if (valid_q && !key_ack) begin
        ovr_d = 1'b1;
      end else begin
        code_d  = {row_d, col_q};
        valid_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD);
  assign overrun   = ovr_q;

endmodule
